// File: rtl/i2c_txn_arbiter_if.sv
// Bundle between the requesters, the transaction arbiter and the shared I2C master.
// The arbiter takes the slave view; the testbench or client glue takes the master view.
interface i2c_txn_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rw;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [7:0]           resp_data;
    logic                 resp_timeout;
    logic                 busy;
    logic                 m_start;
    logic                 m_rw;
    logic [6:0]           m_addr;
    logic [7:0]           m_din;
    logic                 m_done;
    logic [7:0]           m_rx_data;

    modport slave (
        input  req, req_rw, req_addr, req_data, m_done, m_rx_data,
        output grant, resp_valid, resp_data, resp_timeout, busy,
               m_start, m_rw, m_addr, m_din
    );

    modport master (
        output req, req_rw, req_addr, req_data, m_done, m_rx_data,
        input  grant, resp_valid, resp_data, resp_timeout, busy,
               m_start, m_rw, m_addr, m_din
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one single-byte I2C master among NUM_REQ requesters,
// with a WAIT timeout and a DRAIN state that swallows level-style done signals.
module i2c_txn_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic               clk,
    input logic               rst,
    i2c_txn_arbiter_if.slave  bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               m_start_q, m_start_d;
    logic               m_rw_q, m_rw_d;
    logic [6:0]         m_addr_q, m_addr_d;
    logic [7:0]         m_din_q, m_din_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         resp_data_q, resp_data_d;
    logic               resp_timeout_q, resp_timeout_d;

    logic [NUM_REQ-1:0][6:0] addr_a;
    logic [NUM_REQ-1:0][7:0] data_a;
    logic [IDX_W-1:0]        pick;
    logic                    any_req;

    assign addr_a  = bus.req_addr;
    assign data_a  = bus.req_data;
    assign any_req = |bus.req;

    // First requester after the last winner, wrapping; the pointer is the previous winner.
    always_comb begin
        logic found;
        int   idx;
        pick  = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && bus.req[IDX_W'(idx)]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        win_d          = win_q;
        grant_d        = grant_q;
        m_start_d      = 1'b0;
        m_rw_d         = m_rw_q;
        m_addr_d       = m_addr_q;
        m_din_d        = m_din_q;
        cnt_d          = cnt_q;
        resp_data_d    = resp_data_q;
        resp_timeout_d = resp_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    win_d    = pick;
                    grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                    m_rw_d   = bus.req_rw[pick];
                    m_addr_d = addr_a[pick];
                    m_din_d  = data_a[pick];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Registered pulse: the master sees start during the first WAIT cycle.
                m_start_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.m_done) begin
                    resp_data_d    = m_rw_q ? bus.m_rx_data : 8'h00;
                    resp_timeout_d = 1'b0;
                    state_d        = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_data_d    = 8'h00;
                    resp_timeout_d = 1'b1;
                    state_d        = S_RESP;
                end
            end
            S_RESP: begin
                ptr_d    = win_q;
                grant_d  = '0;
                m_rw_d   = 1'b0;
                m_addr_d = '0;
                m_din_d  = '0;
                state_d  = S_DRAIN;
            end
            S_DRAIN: begin
                if (!bus.m_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ptr_q          <= IDX_W'(NUM_REQ - 1);
            win_q          <= '0;
            grant_q        <= '0;
            m_start_q      <= 1'b0;
            m_rw_q         <= 1'b0;
            m_addr_q       <= '0;
            m_din_q        <= '0;
            cnt_q          <= '0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            win_q          <= win_d;
            grant_q        <= grant_d;
            m_start_q      <= m_start_d;
            m_rw_q         <= m_rw_d;
            m_addr_q       <= m_addr_d;
            m_din_q        <= m_din_d;
            cnt_q          <= cnt_d;
            resp_data_q    <= resp_data_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    // Response fields are only meaningful alongside resp_valid, so they read 0 otherwise.
    assign bus.grant        = grant_q;
    assign bus.resp_valid   = (state_q == S_RESP) ? grant_q : '0;
    assign bus.resp_data    = (state_q == S_RESP) ? resp_data_q : 8'h00;
    assign bus.resp_timeout = (state_q == S_RESP) && resp_timeout_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.m_start      = m_start_q;
    assign bus.m_rw         = m_rw_q;
    assign bus.m_addr       = m_addr_q;
    assign bus.m_din        = m_din_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_resp_busy:    assert property (@(posedge clk) disable iff (rst) |bus.resp_valid |-> bus.busy);
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: a vector table of single transactions plus
// hand-written timeout, level-done, reset-abort and round-robin sequences.
module tb_i2c_txn_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    i2c_txn_arbiter_if #(.NUM_REQ(N)) bus ();

    i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0] req;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] din;
        logic [7:0] rx;
        logic [3:0] exp_grant;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_slot(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
        bus.req_rw[i]        = rw;
        bus.req_addr[7*i+:7] = a;
        bus.req_data[8*i+:8] = d;
    endtask

    // Called at a negedge in IDLE with req already driven; returns at a negedge back in IDLE.
    task automatic serve(input logic [3:0] eg, input logic erw, input logic [6:0] ea,
                         input logic [7:0] ed, input logic [7:0] rx, input logic [7:0] er,
                         input string tag);
        tick;
        chk({tag, "_grant"}, 32'(bus.grant), 32'(eg));
        chk({tag, "_addr"},  32'(bus.m_addr), 32'(ea));
        chk({tag, "_din"},   32'(bus.m_din), 32'(ed));
        chk({tag, "_rw"},    32'(bus.m_rw), 32'(erw));
        chk({tag, "_nostart"}, 32'(bus.m_start), 32'd0);
        tick;
        chk({tag, "_start"}, 32'(bus.m_start), 32'd1);
        tick;
        chk({tag, "_start1"}, 32'(bus.m_start), 32'd0);
        bus.m_done    = 1'b1;
        bus.m_rx_data = rx;
        tick;
        chk({tag, "_rvalid"}, 32'(bus.resp_valid), 32'(eg));
        chk({tag, "_rdata"},  32'(bus.resp_data), 32'(er));
        chk({tag, "_rto"},    32'(bus.resp_timeout), 32'd0);
        chk({tag, "_rw_hold"}, 32'(bus.m_rw), 32'(erw));
        bus.m_done = 1'b0;
        bus.req    = bus.req & ~eg;
        tick;
        chk({tag, "_rvalid0"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_grant0"},  32'(bus.grant), 32'd0);
        chk({tag, "_drain"},   32'(bus.busy), 32'd1);
        tick;
        chk({tag, "_idle"},    32'(bus.busy), 32'd0);
    endtask

    // Requester i in the round-robin sequences: reads on odd slots.
    task automatic serve_slot(input int i, input string tag);
        logic       rw;
        logic [7:0] rx;
        rw = (i % 2) == 1;
        rx = 8'h10 + 8'(i);
        serve(4'b0001 << i, rw, 7'h40 + 7'(i), 8'hA0 + 8'(i), rx, rw ? rx : 8'h00, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pulses, starts, notbusy, w;
        bus.req = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_data = '0;
        bus.m_done = 1'b0; bus.m_rx_data = '0;

        vecs[0] = '{req:4'b0010, rw:1'b0, addr:7'h50, din:8'hBE, rx:8'hFF, exp_grant:4'b0010, exp_rdata:8'h00};
        vecs[1] = '{req:4'b0100, rw:1'b1, addr:7'h52, din:8'h00, rx:8'h5A, exp_grant:4'b0100, exp_rdata:8'h5A};
        vecs[2] = '{req:4'b0011, rw:1'b1, addr:7'h10, din:8'h11, rx:8'hC3, exp_grant:4'b0001, exp_rdata:8'hC3};
        vecs[3] = '{req:4'b1010, rw:1'b0, addr:7'h21, din:8'h77, rx:8'h99, exp_grant:4'b0010, exp_rdata:8'h00};
        vecs[4] = '{req:4'b1001, rw:1'b1, addr:7'h7F, din:8'h00, rx:8'h01, exp_grant:4'b1000, exp_rdata:8'h01};
        vecs[5] = '{req:4'b1001, rw:1'b0, addr:7'h00, din:8'h00, rx:8'hAA, exp_grant:4'b0001, exp_rdata:8'h00};

        tick; tick;
        chk("rst_grant",  32'(bus.grant), 32'd0);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_start",  32'(bus.m_start), 32'd0);
        chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
        chk("rst_addr",   32'(bus.m_addr), 32'd0);
        rst = 1'b0;
        tick;

        // Non-winning slots carry decoy fields so a wrong mux select shows up.
        foreach (vecs[v]) begin
            w = 0;
            for (int i = 0; i < N; i++) if (vecs[v].exp_grant[i]) w = i;
            for (int i = 0; i < N; i++) begin
                if (i == w) set_slot(i, vecs[v].rw, vecs[v].addr, vecs[v].din);
                else        set_slot(i, ~vecs[v].rw, 7'h60 + 7'(i), 8'hE0 + 8'(i));
            end
            bus.req = vecs[v].req;
            serve(vecs[v].exp_grant, vecs[v].rw, vecs[v].addr, vecs[v].din,
                  vecs[v].rx, vecs[v].exp_rdata, $sformatf("vec%0d", v));
        end
        bus.req = '0;

        // Timeout with a second requester queued mid-transaction.
        set_slot(2, 1'b0, 7'h2C, 8'h5E);
        bus.req = 4'b0100;
        tick;
        chk("to_grant", 32'(bus.grant), 32'b0100);
        tick;
        chk("to_start", 32'(bus.m_start), 32'd1);
        pulses = 0;
        for (int k = 3; k <= 17; k++) begin
            tick;
            if (bus.resp_valid != '0) pulses++;
            if (k == 5) begin set_slot(0, 1'b1, 7'h33, 8'h00); bus.req[0] = 1'b1; end
        end
        chk("to_early_resp", 32'(pulses), 32'd0);
        tick;
        chk("to_rvalid", 32'(bus.resp_valid), 32'b0100);
        chk("to_flag",   32'(bus.resp_timeout), 32'd1);
        chk("to_rdata",  32'(bus.resp_data), 32'd0);
        bus.req[2] = 1'b0;
        tick;
        chk("to_flag_clr", 32'(bus.resp_timeout), 32'd0);
        tick;
        chk("to_idle", 32'(bus.busy), 32'd0);
        serve(4'b0001, 1'b1, 7'h33, 8'h00, 8'h81, 8'h81, "queued");

        // Level-style done held for 20 cycles.
        set_slot(1, 1'b1, 7'h45, 8'h00);
        bus.req = 4'b0010;
        tick;
        chk("lvl_grant", 32'(bus.grant), 32'b0010);
        tick;
        chk("lvl_start", 32'(bus.m_start), 32'd1);
        tick;
        bus.m_done = 1'b1; bus.m_rx_data = 8'h3C;
        tick;
        chk("lvl_rvalid", 32'(bus.resp_valid), 32'b0010);
        chk("lvl_rdata",  32'(bus.resp_data), 32'h3C);
        bus.req[1] = 1'b0;
        set_slot(3, 1'b0, 7'h2A, 8'h5C);
        bus.req[3] = 1'b1;
        pulses = 0; starts = 0; notbusy = 0;
        for (int k = 5; k <= 23; k++) begin
            tick;
            if (bus.resp_valid != '0) pulses++;
            if (bus.m_start) starts++;
            if (!bus.busy) notbusy++;
            if (k == 23) bus.m_done = 1'b0;
        end
        chk("lvl_extra_resp", 32'(pulses), 32'd0);
        chk("lvl_starts", 32'(starts), 32'd0);
        chk("lvl_notbusy", 32'(notbusy), 32'd0);
        tick;
        chk("lvl_idle", 32'(bus.busy), 32'd0);
        serve(4'b1000, 1'b0, 7'h2A, 8'h5C, 8'hEE, 8'h00, "after_lvl");

        // Reset in WAIT, then round-robin from a fresh pointer.
        set_slot(2, 1'b1, 7'h12, 8'h34);
        bus.req = 4'b0100;
        tick; tick;
        chk("rw_start", 32'(bus.m_start), 32'd1);
        tick;
        rst = 1'b1;
        tick;
        chk("rw_grant",  32'(bus.grant), 32'd0);
        chk("rw_rvalid", 32'(bus.resp_valid), 32'd0);
        chk("rw_busy",   32'(bus.busy), 32'd0);
        chk("rw_mrw",    32'(bus.m_rw), 32'd0);
        chk("rw_maddr",  32'(bus.m_addr), 32'd0);
        chk("rw_rto",    32'(bus.resp_timeout), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_slot(i, (i % 2) == 1, 7'h40 + 7'(i), 8'hA0 + 8'(i));
        bus.req = 4'b1111;
        serve_slot(0, "rr0");
        bus.req = 4'b1111; serve_slot(1, "rr1");
        bus.req = 4'b1111; serve_slot(2, "rr2");
        bus.req = 4'b1111; serve_slot(3, "rr3");
        bus.req = 4'b1111; serve_slot(0, "rr0b");
        bus.req = 4'b1001; serve_slot(3, "rr9_3");
        bus.req = 4'b1001; serve_slot(0, "rr9_0");
        bus.req = '0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
